// File: rtl/rr_priority_arbiter_if.sv
// rtl/rr_priority_arbiter_if.sv - request/grant bundle for rr_priority_arbiter (lock only with ARB_LOCK_EN)
interface rr_priority_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]   req;
`ifdef ARB_LOCK_EN
    logic           lock;
`endif
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;

    modport master (
`ifdef ARB_LOCK_EN
        input  lock,
`endif
        input  req,
        output gnt, gnt_valid, gnt_id
    );

    modport slave (
`ifdef ARB_LOCK_EN
        output lock,
`endif
        output req,
        input  gnt, gnt_valid, gnt_id
    );
endinterface

// File: rtl/rr_priority_arbiter.sv
// rtl/rr_priority_arbiter.sv - N-way fixed/round-robin arbiter with registered grant and burst cap
// Optional feature macro: ARB_LOCK_EN (lock input overrides the burst cap)
module rr_priority_arbiter #(
    parameter int N        = 4,
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_priority_arbiter_if.master bus
);
    localparam int IDW = $clog2(N);
    localparam int HW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]  hold_q, hold_d;

    logic           owner_req;
    logic           lock_hold;
    logic           cap_hit;
    logic [HW-1:0]  hold_inc;
    logic [N-1:0]   cand;
    logic [IDW-1:0] win;
    logic           new_grant;

    // First set bit of c scanning upward from start, wrapping at N-1.
    function automatic logic [IDW-1:0] pick(input logic [N-1:0] c, input logic [IDW-1:0] start);
        logic [IDW-1:0] idx;
        logic           found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = IDW'((int'(start) + k) % N);
            if (!found && c[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] x);
        next_ptr = (x == IDW'(N - 1)) ? '0 : x + IDW'(1);
    endfunction

    always_comb begin
        owner_req = bus.req[owner_q];
`ifdef ARB_LOCK_EN
        lock_hold = bus.lock & owner_req;
`else
        lock_hold = 1'b0;
`endif
        cap_hit  = (MAX_HOLD != 0) && (hold_q >= HW'(MAX_HOLD)) && !lock_hold;
        hold_inc = (&hold_q) ? hold_q : hold_q + HW'(1);
        // The capped owner sits out exactly one arbitration.
        cand     = bus.req & ~((state_q == GRANT && cap_hit) ? (ONE << owner_q) : '0);
        win      = pick(cand, (RR_MODE != 0) ? rr_ptr_q : '0);
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        new_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (|cand) new_grant = 1'b1;
            end
            GRANT: begin
                if (owner_req && !cap_hit) begin
                    hold_d = hold_inc;
                end else if (|cand) begin
                    new_grant = 1'b1;
                end else if (cap_hit && owner_req) begin
                    hold_d   = HW'(1);
                    rr_ptr_d = next_ptr(owner_q);
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    owner_d = '0;
                    hold_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (new_grant) begin
            state_d  = GRANT;
            gnt_d    = ONE << win;
            owner_d  = win;
            hold_d   = HW'(1);
            rr_ptr_d = next_ptr(win);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.gnt_id    = owner_q;
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb/tb_rr_priority_arbiter.sv - directed bench for rr_priority_arbiter, fixed and round-robin instances
module tb_rr_priority_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    rr_priority_arbiter_if #(.N(4)) bus_fp ();
    rr_priority_arbiter_if #(.N(4)) bus_rr ();

    rr_priority_arbiter #(.N(4), .RR_MODE(0), .MAX_HOLD(4)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fp)
    );

    rr_priority_arbiter #(.N(4), .RR_MODE(1), .MAX_HOLD(4)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_rr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // owner < 0 means no grant expected
    task automatic chk_fp(input string tag, input int owner);
        chk({tag, "_fp_gnt"},   32'(bus_fp.gnt),       (owner < 0) ? 32'd0 : (32'd1 << owner));
        chk({tag, "_fp_valid"}, 32'(bus_fp.gnt_valid), (owner < 0) ? 32'd0 : 32'd1);
        chk({tag, "_fp_id"},    32'(bus_fp.gnt_id),    (owner < 0) ? 32'd0 : 32'(owner));
    endtask

    task automatic chk_rr(input string tag, input int owner);
        chk({tag, "_rr_gnt"},   32'(bus_rr.gnt),       (owner < 0) ? 32'd0 : (32'd1 << owner));
        chk({tag, "_rr_valid"}, 32'(bus_rr.gnt_valid), (owner < 0) ? 32'd0 : 32'd1);
        chk({tag, "_rr_id"},    32'(bus_rr.gnt_id),    (owner < 0) ? 32'd0 : 32'(owner));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] v);
        bus_fp.req = v;
        bus_rr.req = v;
    endtask

    task automatic set_lock(input logic v);
`ifdef ARB_LOCK_EN
        bus_fp.lock = v;
        bus_rr.lock = v;
`else
        if (v) $display("lock ignored in this build");
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(4'b0000);
        set_lock(1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b0;
        n_chk  = 0;
        n_pass = 0;
        set_req(4'b1111);
        set_lock(1'b0);

        // reset held two edges with all requests up
        for (int c = 0; c < 2; c++) begin
            tick();
            chk_fp("rst", -1);
            chk_rr("rst", -1);
        end
        rst_n = 1'b1;
        tick();
        chk_fp("rst_rel", 0);
        chk_rr("rst_rel", 0);

        // fixed priority with cap: 1 x4, 3 x4, back to 1
        do_reset();
        set_req(4'b1010);
        for (int c = 0; c < 9; c++) begin
            tick();
            chk_fp("fixed", (c < 4) ? 1 : (c < 8) ? 3 : 1);
        end

        // all requesting: rr rotates 0..3, fixed alternates 0/1
        do_reset();
        set_req(4'b1111);
        for (int c = 0; c < 17; c++) begin
            tick();
            chk_rr("rot", (c / 4) % 4);
            chk_fp("alt", (c / 4) % 2);
        end

        // early release hands over with no bubble
        do_reset();
        set_req(4'b0100);
        tick();
        chk_fp("early0", 2);
        tick();
        chk_fp("early1", 2);
        set_req(4'b0001);
        tick();
        chk_fp("early2", 0);

        // lone requester at cap never loses the grant
        do_reset();
        set_req(4'b0001);
        for (int c = 0; c < 12; c++) begin
            tick();
            chk_fp("lone", 0);
            chk_rr("lone", 0);
        end

        // lock extends a burst; mid-burst reset drops the grant
        do_reset();
        set_lock(1'b1);
        set_req(4'b0011);
`ifdef ARB_LOCK_EN
        for (int c = 0; c < 6; c++) begin
            tick();
            chk_fp("lock", 0);
        end
        set_lock(1'b0);
        tick();
        chk_fp("unlock", 1);
        tick();
        chk_fp("unlock_hold", 1);
`else
        for (int c = 0; c < 8; c++) begin
            tick();
            chk_fp("nolock", (c < 4) ? 0 : 1);
        end
`endif
        rst_n = 1'b0;
        tick();
        chk_fp("mid_rst", -1);
        chk_rr("mid_rst", -1);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
